// File: rtl/uart_pkg.sv
// Shared UART transmitter types/constants; UART_TX_PARITY_EN adds the PARITY state.
// No logic here: latency and backpressure are properties of the modules that import it.
package uart_pkg;

  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: tick high on the last cycle of every CLKS_PER_BIT period.
// Latency: first tick CLKS_PER_BIT cycles after clear drops; no backpressure, clear wins.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == LAST) && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB first, one stop bit; even parity bit when UART_TX_PARITY_EN is defined.
// Latency: start bit on tx one cycle after a rising transmit; requests while busy are dropped, never queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  transmit,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int            IW       = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  uart_tx_state_t        state_q;
  uart_tx_state_t        state_d;
  logic                  transmit_q;
  logic                  start_evt;
  logic                  accept;
  logic                  tick;
  logic                  last_bit;
  logic [IW-1:0]         bit_idx_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] shreg_d;
  logic                  tx_q;
  logic                  tx_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  assign start_evt = transmit & ~transmit_q;
  assign accept    = (state_q == ST_IDLE) && start_evt;
  assign last_bit  = (bit_idx_q == LAST_BIT);
  assign tx        = tx_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_evt) state_d = ST_START;
      ST_START: if (tick) state_d = ST_DATA;
`ifdef UART_TX_PARITY_EN
      ST_DATA:   if (tick && last_bit) state_d = ST_PARITY;
      ST_PARITY: if (tick) state_d = ST_STOP;
`else
      ST_DATA:  if (tick && last_bit) state_d = ST_STOP;
`endif
      ST_STOP:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // tx is computed from the next state so the line itself comes straight off a flop.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_STOP) && tick;
    shreg_d = shreg_q;
    if (accept) begin
      shreg_d = data;
    end else if ((state_q == ST_DATA) && tick) begin
      shreg_d = shreg_q >> 1;
    end
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = IDLE_LEVEL;
    endcase
  end

  // transmit_q resets high so a level already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      transmit_q <= 1'b1;
      tx_q       <= IDLE_LEVEL;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
    end else begin
      transmit_q <= transmit;
      tx_q       <= tx_d;
      shreg_q    <= shreg_d;
      if (state_q != ST_DATA) begin
        bit_idx_q <= '0;
      end else if (tick) begin
        bit_idx_q <= bit_idx_q + IW'(1);
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^data;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, DATA_WIDTH=8; parity cases follow UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          transmit;
  logic [DW-1:0] data;
  logic          tx;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .transmit(transmit),
    .data    (data),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  // frame bit i = line level during bit period i (start .. stop, no parity)
  typedef struct {
    logic [7:0] data;
    logic [7:0] late;
    bit         late_en;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [2:0] exp_at(int c, logic [9:0] frame, logic par);
    int   b;
    logic t;
    if (c < 1 || c > FLEN) return 3'b100;
    b = (c - 1) / CPB;
    if (b < 9) t = frame[b];
    else if (NBITS == 11 && b == 9) t = par;
    else t = 1'b1;
    return {t, 1'b1, (c == FLEN)};
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: tx/busy/done got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(output logic [2:0] s);
    @(negedge clk);
    s = {tx, busy, done};
  endtask

  // Transmit rises at cycle 0, optionally drops at c_low and rises again at c_high.
  task automatic run_sched(input string tag, input vec_t v, input int ncyc,
                           input int c_low, input int c_high, output int n_done);
    logic [2:0] s;
    n_done = 0;
    data = v.data;
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0) transmit = 1'b1;
      if (c == c_low) transmit = 1'b0;
      if (c == c_high) transmit = 1'b1;
      if (v.late_en && c == 2) data = v.late;
      sample(s);
      if (s[0]) n_done++;
      check($sformatf("%s c%0d", tag, c), s, exp_at(c, v.frame, v.par));
      step();
    end
    transmit = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    logic [2:0] s;
    int         nd;
    int         nstart;
    logic       prev_busy;

    vecs[0] = '{8'hA5, 8'h00, 1'b0, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h3C, 8'hFF, 1'b1, 10'b1001111000, 1'b0};
    vecs[2] = '{8'h01, 8'h00, 1'b0, 10'b1000000010, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 10'b1000000000, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 10'b1111111110, 1'b0};

    rst_n    = 1'b0;
    transmit = 1'b0;
    data     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", {tx, busy, done}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      run_sched($sformatf("vec%0d", i), vecs[i], FLEN + 6, -1, -1, nd);
      check_int($sformatf("vec%0d done pulses", i), nd, 1);
    end

    // Level held high: one frame only
    data = 8'h5A;
    transmit = 1'b1;
    nd = 0;
    nstart = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 200; c++) begin
      sample(s);
      if (s[0]) nd++;
      if (s[1] && !prev_busy) nstart++;
      prev_busy = s[1];
      step();
    end
    check_int("held-high done pulses", nd, 1);
    check_int("held-high frames", nstart, 1);
    transmit = 1'b0;
    repeat (3) step();

    run_sched("retrig12", vecs[0], FLEN + 60, 5, 12, nd);
    check_int("retrig12 done pulses", nd, 1);

    run_sched("retrig_done", vecs[0], FLEN + 40, 10, FLEN, nd);
    check_int("retrig_done done pulses", nd, 1);

    // Reset mid-frame with transmit still high through release
    data = 8'hA5;
    transmit = 1'b1;
    for (int c = 0; c < 20; c++) begin
      sample(s);
      check($sformatf("prereset c%0d", c), s, exp_at(c, vecs[0].frame, vecs[0].par));
      step();
    end
    rst_n = 1'b0;
    #1;
    check("reset mid-frame", {tx, busy, done}, 3'b100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      sample(s);
      if (s[1]) nd++;
      step();
    end
    check_int("post-reset busy cycles", nd, 0);
    check("post-reset line", {tx, busy, done}, 3'b100);
    transmit = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
